// File: rtl/mem_mc_arb_if.sv
// Request/response bundle between the memory agents and mem_mc_arb.
// One valid/ready request channel and one read-response channel per agent.
interface mem_mc_arb_if #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) ();
  localparam int NB = DATA_WIDTH / 8;

  logic [NUM_CH-1:0]            valid_i;
  logic [NUM_CH-1:0]            ready_o;
  logic [NUM_CH-1:0]            wr_rd_i;
  logic [NUM_CH*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_CH*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_CH*NB-1:0]         be_i;
  logic [NUM_CH*DATA_WIDTH-1:0] rdata_o;
  logic [NUM_CH-1:0]            rvalid_o;
  logic                         err_inj_i;
  logic [NUM_CH-1:0]            perr_o;

  modport master (
    output valid_i, wr_rd_i, addr_i, wdata_i, be_i, err_inj_i,
    input  ready_o, rdata_o, rvalid_o, perr_o
  );

  modport slave (
    input  valid_i, wr_rd_i, addr_i, wdata_i, be_i, err_inj_i,
    output ready_o, rdata_o, rvalid_o, perr_o
  );
endinterface

// File: rtl/mem_mc_arb.sv
// Round-robin arbitrated single-port RAM shared by NUM_CH request channels.
// Optional per-byte even parity with error injection: define MEM_PARITY_EN.
module mem_mc_arb #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  mem_mc_arb_if.slave    bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PW-1:0]              rr_ptr_r;
  logic [NUM_CH-1:0]          gnt_vec_s;
  logic [PW-1:0]              gnt_idx_s;
  logic                       gnt_s;
  logic                       sel_wr_s;
  logic [ADDR_WIDTH-1:0]      sel_addr_s;
  logic [DATA_WIDTH-1:0]      sel_wdata_s;
  logic [NB-1:0]              sel_be_s;
  int                         scan_s;

  logic [DATA_WIDTH-1:0]        mem_r [DEPTH];
  logic [NUM_CH*DATA_WIDTH-1:0] rdata_r;
  logic [NUM_CH-1:0]            rvalid_r;
  logic [NUM_CH-1:0]            perr_r;

`ifdef MEM_PARITY_EN
  logic [NB-1:0] par_r [DEPTH];

  function automatic logic [NB-1:0] byte_parity(input logic [DATA_WIDTH-1:0] word);
    logic [NB-1:0] par;
    par = '0;
    for (int b = 0; b < NB; b++) begin
      par[b] = ^word[b*8 +: 8];
    end
    return par;
  endfunction
`endif

  // Arbiter: first valid channel at or after the round-robin pointer wins.
  always_comb begin
    gnt_vec_s   = '0;
    gnt_idx_s   = '0;
    gnt_s       = 1'b0;
    sel_wr_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_be_s    = '0;
    scan_s      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_s = (int'(rr_ptr_r) + i) % NUM_CH;
      if (rst_ni && !gnt_s && bus.valid_i[scan_s]) begin
        gnt_s             = 1'b1;
        gnt_idx_s         = PW'(scan_s);
        gnt_vec_s[scan_s] = 1'b1;
        sel_wr_s          = bus.wr_rd_i[scan_s];
        sel_addr_s        = bus.addr_i[scan_s*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_s       = bus.wdata_i[scan_s*DATA_WIDTH +: DATA_WIDTH];
        sel_be_s          = bus.be_i[scan_s*NB +: NB];
      end else begin
        gnt_vec_s = gnt_vec_s;
      end
    end
  end

  // Round-robin pointer moves past the granted channel on every transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_r <= '0;
    end else if (gnt_s) begin
      rr_ptr_r <= (int'(gnt_idx_s) == NUM_CH - 1) ? '0 : gnt_idx_s + PW'(1);
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (gnt_s && sel_wr_s) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_be_s[b]) begin
          mem_r[sel_addr_s][b*8 +: 8] <= sel_wdata_s[b*8 +: 8];
`ifdef MEM_PARITY_EN
          par_r[sel_addr_s][b] <= (^sel_wdata_s[b*8 +: 8]) ^ bus.err_inj_i;
`endif
        end
      end
    end
  end

  // Registered read response routed back to the granted channel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_r  <= '0;
      rvalid_r <= '0;
      perr_r   <= '0;
    end else begin
      rvalid_r <= '0;
      perr_r   <= '0;
      if (gnt_s && !sel_wr_s) begin
        rdata_r[gnt_idx_s*DATA_WIDTH +: DATA_WIDTH] <= mem_r[sel_addr_s];
        rvalid_r[gnt_idx_s] <= 1'b1;
`ifdef MEM_PARITY_EN
        perr_r[gnt_idx_s] <= |(par_r[sel_addr_s] ^ byte_parity(mem_r[sel_addr_s]));
`endif
      end
    end
  end

`ifndef MEM_PARITY_EN
  logic unused_err_inj_s;
  assign unused_err_inj_s = bus.err_inj_i;
`endif

  assign bus.ready_o  = gnt_vec_s;
  assign bus.rdata_o  = rdata_r;
  assign bus.rvalid_o = rvalid_r;
  assign bus.perr_o   = perr_r;
endmodule

// File: tb/tb_mem_mc_arb.sv
// Directed self-checking bench for mem_mc_arb with two channels.
// Parity expectations follow MEM_PARITY_EN when defined for the build.
module tb_mem_mc_arb;
  localparam int NUM_CH = 2;
  localparam int AW     = 10;
  localparam int DW     = 32;
`ifdef MEM_PARITY_EN
  localparam logic [1:0] PERR_INJ = 2'b01;
`else
  localparam logic [1:0] PERR_INJ = 2'b00;
`endif

  logic clk;
  logic rst_ni;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_mc_arb_if #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_mc_arb #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester contract: a pending request keeps valid high and its payload stable.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_req
    assert property (@(posedge clk) disable iff (!rst_ni)
      (bus.valid_i[c] && !bus.ready_o[c]) |=>
        (bus.valid_i[c] && $stable(bus.addr_i[c*AW +: AW]) && $stable(bus.wr_rd_i[c])))
      else $error("requester contract broken on ch%0d", c);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise one request and hold it until granted; returns 1 time unit after the handshake edge.
  task automatic xfer(input int ch, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [3:0] be, input logic inj);
    bit done;
    int cyc;
    bus.wr_rd_i[ch]           = wr;
    bus.addr_i[ch*AW +: AW]   = addr;
    bus.wdata_i[ch*DW +: DW]  = wd;
    bus.be_i[ch*4 +: 4]       = be;
    bus.err_inj_i             = inj;
    bus.valid_i[ch]           = 1'b1;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 20) begin
      #1;
      if (bus.ready_o[ch]) done = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.valid_i[ch] = 1'b0;
    bus.err_inj_i   = 1'b0;
    check_val("xfer_grant", {63'd0, done}, 64'd1);
  endtask

  task automatic rd_check(input string tag, input int ch, input logic [AW-1:0] addr,
                          input logic [DW-1:0] exp, input logic [1:0] exp_perr);
    xfer(ch, 1'b0, addr, 32'h0, 4'h0, 1'b0);
    check_val({tag, "_rvalid"}, {62'd0, bus.rvalid_o}, 64'd1 << ch);
    check_val({tag, "_rdata"}, {32'd0, bus.rdata_o[ch*DW +: DW]}, {32'd0, exp});
    check_val({tag, "_perr"}, {62'd0, bus.perr_o}, {62'd0, exp_perr});
  endtask

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return 32'hC0DE_0000 + {22'd0, a} * 32'h0001_0101;
  endfunction

  int cnt0;
  int cnt1;
  int exp_g;

  initial begin
    rst_ni        = 1'b0;
    bus.valid_i   = 2'b11;
    bus.wr_rd_i   = 2'b00;
    bus.addr_i    = '0;
    bus.wdata_i   = '0;
    bus.be_i      = '0;
    bus.err_inj_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready",  {62'd0, bus.ready_o},  64'd0);
    check_val("rst_rvalid", {62'd0, bus.rvalid_o}, 64'd0);
    check_val("rst_rdata",  {bus.rdata_o},         64'd0);
    check_val("rst_perr",   {62'd0, bus.perr_o},   64'd0);
    rst_ni = 1'b1;
    #1;
    check_val("rel_ready_ch0", {62'd0, bus.ready_o}, 64'd1);
    @(posedge clk);
    #1;
    bus.valid_i = 2'b10;
    #1;
    check_val("rel_ready_ch1", {62'd0, bus.ready_o}, 64'd2);
    @(posedge clk);
    #1;
    bus.valid_i = 2'b00;

    // Single channel write then read, with exact one-cycle response pulse.
    xfer(0, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 1'b0);
    rd_check("wr_rd", 0, 10'h005, 32'hDEADBEEF, 2'b00);
    @(posedge clk);
    #1;
    check_val("rvalid_one_cycle", {62'd0, bus.rvalid_o}, 64'd0);
    check_val("rdata_hold", {32'd0, bus.rdata_o[31:0]}, 64'hDEADBEEF);

    // Byte enables, including an all-zero enable no-op.
    xfer(0, 1'b1, 10'h010, 32'h11223344, 4'hF, 1'b0);
    xfer(0, 1'b1, 10'h010, 32'hAABBCCDD, 4'b0101, 1'b0);
    rd_check("be_merge", 0, 10'h010, 32'h11BB33DD, 2'b00);
    xfer(0, 1'b1, 10'h010, 32'h12345678, 4'h0, 1'b0);
    rd_check("be_zero", 0, 10'h010, 32'h11BB33DD, 2'b00);

    // Preload; last write on ch1 leaves the pointer at ch0.
    for (int a = 0; a < 3; a++) xfer(0, 1'b1, AW'(10'h020 + a), pat(AW'(10'h020 + a)), 4'hF, 1'b0);
    for (int a = 0; a < 3; a++) xfer(1, 1'b1, AW'(10'h023 + a), pat(AW'(10'h023 + a)), 4'hF, 1'b0);

    // Full contention: grants alternate ch0, ch1, ...
    cnt0 = 0;
    cnt1 = 0;
    bus.wr_rd_i = 2'b00;
    for (int k = 0; k < 6; k++) begin
      bus.valid_i = {(cnt1 < 3), (cnt0 < 3)};
      bus.addr_i[0 +: AW]  = AW'(10'h020 + cnt0);
      bus.addr_i[AW +: AW] = AW'(10'h023 + cnt1);
      exp_g = k % 2;
      #1;
      check_val("rr_ready", {62'd0, bus.ready_o}, 64'd1 << exp_g);
      @(posedge clk);
      #1;
      check_val("rr_rvalid", {62'd0, bus.rvalid_o}, 64'd1 << exp_g);
      if (exp_g == 0) begin
        check_val("rr_rdata0", {32'd0, bus.rdata_o[0 +: DW]}, {32'd0, pat(AW'(10'h020 + cnt0))});
        cnt0++;
      end else begin
        check_val("rr_rdata1", {32'd0, bus.rdata_o[DW +: DW]}, {32'd0, pat(AW'(10'h023 + cnt1))});
        cnt1++;
      end
    end
    bus.valid_i = 2'b00;

    // Write on ch1 immediately followed by a read of the same word on ch0.
    xfer(1, 1'b1, 10'h3FF, 32'hCAFEF00D, 4'hF, 1'b0);
    rd_check("hazard", 0, 10'h3FF, 32'hCAFEF00D, 2'b00);

    // Parity error injection and clean rewrite.
    xfer(0, 1'b1, 10'h040, 32'h0, 4'hF, 1'b1);
    rd_check("par_inj", 0, 10'h040, 32'h0, PERR_INJ);
    xfer(0, 1'b1, 10'h040, 32'h0, 4'hF, 1'b0);
    rd_check("par_clean", 0, 10'h040, 32'h0, 2'b00);

    // Reset mid-operation: response dropped, write blocked, pointer back to ch0.
    xfer(0, 1'b0, 10'h005, 32'h0, 4'h0, 1'b0);
    check_val("pre_rst_rvalid", {62'd0, bus.rvalid_o}, 64'd1);
    rst_ni = 1'b0;
    #1;
    check_val("mid_rst_rvalid", {62'd0, bus.rvalid_o}, 64'd0);
    check_val("mid_rst_rdata", bus.rdata_o, 64'd0);
    bus.wr_rd_i[0] = 1'b1;
    bus.wdata_i[0 +: DW] = 32'hFFFFFFFF;
    bus.be_i[0 +: 4] = 4'hF;
    bus.valid_i = 2'b01;
    #1;
    check_val("mid_rst_ready", {62'd0, bus.ready_o}, 64'd0);
    @(posedge clk);
    #1;
    bus.valid_i = 2'b00;
    rst_ni = 1'b1;
    bus.wr_rd_i = 2'b00;
    bus.addr_i[0 +: AW]  = 10'h005;
    bus.addr_i[AW +: AW] = 10'h010;
    bus.valid_i = 2'b11;
    #1;
    check_val("post_rst_ready", {62'd0, bus.ready_o}, 64'd1);
    @(posedge clk);
    #1;
    check_val("post_rst_rvalid0", {62'd0, bus.rvalid_o}, 64'd1);
    check_val("post_rst_rdata0", {32'd0, bus.rdata_o[0 +: DW]}, 64'hDEADBEEF);
    bus.valid_i = 2'b10;
    #1;
    check_val("post_rst_ready1", {62'd0, bus.ready_o}, 64'd2);
    @(posedge clk);
    #1;
    check_val("post_rst_rvalid1", {62'd0, bus.rvalid_o}, 64'd2);
    check_val("post_rst_rdata1", {32'd0, bus.rdata_o[DW +: DW]}, 64'h11BB33DD);
    bus.valid_i = 2'b00;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
